byte_reg_arbiter: RTL and testbench
===================================

# byte_reg_arbiter

Round-robin arbiter that shares one byte-enabled storage register between several write requesters. Each requester presents a request, per-byte enables and write data; the arbiter grants one requester at a time and merges that requester's enabled bytes into the shared register. It sits in front of the byte-enabled DFF datapath and drives its enables and data, so multiple masters can update individual bytes without corrupting each other's writes.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- WIDTH, 16, register width in bits; multiple of 8
- NBYTES, WIDTH/8, derived; not overridable

Ports:
- clk  in  1  single clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester write request, level
- be  in  NREQ*NBYTES  byte enables; requester i owns bits [i*NBYTES +: NBYTES]; bit k enables byte k ([8k+7:8k])
- wdata  in  NREQ*WIDTH  write data; requester i owns [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant pulse, registered
- q  out  WIDTH  shared register contents
- busy  out  1  high while in WRITE state

## Operation
- Two states: ARB, WRITE.
- ARB: if any req bit is high, select the winner by round-robin starting at (ptr+1) mod NREQ. At the clock edge, latch the winner index and its be/wdata slices, set gnt[winner]=1, ptr=winner, and go to WRITE. If no req bit is high, stay in ARB with gnt=0.
- WRITE: gnt holds the one-hot winner for exactly this cycle. At the edge, q byte k = latched wdata byte k if latched be[k]=1, else unchanged. Then gnt=0 and the state returns to ARB.
- req, be and wdata are sampled only in ARB. Values during WRITE are ignored.
- A requester must hold req, be and wdata stable until it samples gnt high, then drop req the next cycle. A req still high in the ARB cycle after its grant is treated as a new request.
- be=0 from the winner is still granted and consumes a slot. q is unchanged.
- req changes on a non-winner during WRITE have no effect. Only the ARB-cycle value counts.
- NREQ=1 degenerates to a request/grant every two cycles.

## Timing
- Throughput: at most one write per 2 cycles.
- Request high in ARB cycle N → gnt during N+1 → new q visible in N+2.
- busy = (state==WRITE); equals |gnt.
- Reset values (asynchronous, on resetn=0): q=0, gnt=0, busy=0, state=ARB, ptr=NREQ-1, so requester 0 wins first.
- Reset asserted during WRITE: the pending write is discarded, and gnt and busy drop immediately without waiting for a clock edge.
- Reset release: the first arbitration is in the first ARB cycle after resetn rises.
- Round-robin wrap: ptr=NREQ-1 → search begins at 0.
- Simultaneous requests: the winner is the first set bit scanning upward from ptr+1 with wrap. Every continuously requesting master is served within NREQ grants.

## Structure
- Shared package: state enum {ARB, WRITE}; localparam-compatible function computing NBYTES; rr_pick function (req vector, ptr → winner index plus valid).
- One natural sub-module, be_reg: WIDTH-bit register with async active-low reset, per-byte enable, and data/enable inputs. The arbiter instantiates it and drives its enables only in WRITE.
- Arbitration state, ptr and latched be/wdata live in the top module.

## Test plan
- Reset: hold resetn=0 with req=2'b11 → q=16'h0000, gnt=0, busy=0. Assert resetn=0 mid-WRITE → gnt falls before the next edge, and q stays at its pre-write value after release.
- Single write: req0=1, be0=2'b11, wdata0=16'habcd → gnt=2'b01 one cycle later, q=16'habcd the cycle after. Next write be0=2'b10, wdata0=16'h1234 → q=16'h12cd.
- Byte merge: q=16'habcd, req1 be1=2'b01 wdata1=16'hff55 → q=16'hab55. be1=2'b00 → gnt=2'b10 pulses and q is unchanged.
- Contention: both req held high after reset → gnt sequence 01,10,01,10 on alternate cycles, with busy toggling 0,1,0,1.
- Wrap and fairness with NREQ=4: all four requesting → grants 0,1,2,3,0. Drop req2 → sequence 0,1,3,0.
- Random: 400 cycles of random req/be/wdata obeying the handshake, checked against a scoreboard merging granted bytes → zero q mismatches, and no requester waits more than 2*NREQ cycles.

Source files
------------

// File: rtl/byte_reg_arbiter_pkg.sv
// Shared types and helpers for the byte-enabled register arbiter.
// Requester indices are 3 bits wide, which allows up to MAX_REQ requesters.
package byte_reg_arbiter_pkg;

    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        WRITE = 1'b1
    } state_e;

    localparam logic [0:0] ST_ARB   = 1'(ARB);
    localparam logic [0:0] ST_WRITE = 1'(WRITE);

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;

    function automatic int unsigned calc_nbytes(input int unsigned width);
        return width / 8;
    endfunction

    // The winner is the first set request found scanning upward from ptr+1,
    // wrapping at nreq.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [2:0]         ptr,
                                      input int unsigned        nreq);
        pick_t      pick;
        logic [2:0] cand;
        pick = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            cand = 3'((32'(ptr) + k) % nreq);
            if (k <= nreq && !pick.valid && req[cand]) begin
                pick.valid = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/byte_reg_arbiter_if.sv
// Requester-side bus of the arbiter: requests, byte enables and write data in;
// grants, shared register contents and busy out.
interface byte_reg_arbiter_if
    import byte_reg_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned NBYTES = calc_nbytes(WIDTH);

    logic [NREQ-1:0]        req;
    logic [NREQ*NBYTES-1:0] be;
    logic [NREQ*WIDTH-1:0]  wdata;
    logic [NREQ-1:0]        gnt;
    logic [WIDTH-1:0]       q;
    logic                   busy;

    modport master (output req, be, wdata, input gnt, q, busy);
    modport slave  (input req, be, wdata, output gnt, q, busy);

endinterface

// File: rtl/byte_reg_arbiter_be_reg.sv
// WIDTH-bit storage register; each byte loads from d_i when its enable bit is set.
module byte_reg_arbiter_be_reg
    import byte_reg_arbiter_pkg::*;
#(
    parameter  int unsigned WIDTH  = 16,
    localparam int unsigned NBYTES = calc_nbytes(WIDTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NBYTES-1:0] en_i,
    input  logic [WIDTH-1:0]  d_i,
    output logic [WIDTH-1:0]  q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q <= '0;
        end else begin
            for (int k = 0; k < int'(NBYTES); k++) begin
                if (en_i[k]) q_q[8*k +: 8] <= d_i[8*k +: 8];
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/byte_reg_arbiter.sv
// Round-robin arbiter merging one granted requester's enabled bytes per two
// cycles into a shared byte-enabled register.
//
//   state    | meaning
//   ST_ARB   | pick a winner among active requests, latch its be/wdata
//   ST_WRITE | grant pulse high; latched bytes land in the register at the edge
module byte_reg_arbiter
    import byte_reg_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ   = 2,
    parameter  int unsigned WIDTH  = 16,
    localparam int unsigned NBYTES = calc_nbytes(WIDTH)
) (
    input  logic         clk,
    input  logic         resetn,
    byte_reg_arbiter_if.slave bus
);

    logic [0:0]         state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NBYTES-1:0]  be_q, be_d, be_sel, wr_en;
    logic [WIDTH-1:0]   wdata_q, wdata_d, wdata_sel;
    logic [MAX_REQ-1:0] req_pad;
    pick_t              pick;

    always_comb begin
        req_pad = '0;
        req_pad[NREQ-1:0] = bus.req;
    end

    assign pick = rr_pick(req_pad, ptr_q, NREQ);

    always_comb begin
        be_sel    = '0;
        wdata_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick.idx == 3'(i)) begin
                be_sel    = bus.be[i*NBYTES +: NBYTES];
                wdata_sel = bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        be_d    = be_q;
        wdata_d = wdata_q;
        if (state_q == ST_ARB) begin
            if (pick.valid) begin
                state_d = ST_WRITE;
                ptr_d   = pick.idx;
                be_d    = be_sel;
                wdata_d = wdata_sel;
                for (int unsigned i = 0; i < NREQ; i++) begin
                    gnt_d[i] = (pick.idx == 3'(i));
                end
            end
        end else begin
            state_d = ST_ARB;
        end
    end

    // Reset drops gnt/busy asynchronously, so a write caught mid-WRITE never lands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_ARB;
            ptr_q   <= 3'(NREQ - 1);
            gnt_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    assign wr_en = (state_q == ST_WRITE) ? be_q : '0;

    byte_reg_arbiter_be_reg #(.WIDTH(WIDTH)) u_be_reg (
        .clk    (clk),
        .resetn (resetn),
        .en_i   (wr_en),
        .d_i    (wdata_q),
        .q_o    (bus.q)
    );

    assign bus.gnt  = gnt_q;
    assign bus.busy = (state_q == ST_WRITE);

endmodule

// File: tb/tb_byte_reg_arbiter.sv
// Scoreboard bench: drivers queue expected grants/register values, negedge
// monitors pop and compare whenever a grant appears.
module tb_byte_reg_arbiter;

    typedef struct { logic [7:0] gnt; logic [15:0] q; } exp_t;
    typedef struct { logic [1:0] be; logic [15:0] wd; int t0; } tx_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    byte_reg_arbiter_if #(.NREQ(2), .WIDTH(16)) bus2();
    byte_reg_arbiter_if #(.NREQ(4), .WIDTH(16)) bus4();

    byte_reg_arbiter #(.NREQ(2), .WIDTH(16)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2));
    byte_reg_arbiter #(.NREQ(4), .WIDTH(16)) dut4 (.clk(clk), .resetn(resetn), .bus(bus4));

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b0;
    bit          rnd    = 1'b0;
    bit          pend2  = 1'b0;
    logic [15:0] expq2;
    logic [15:0] model;
    exp_t        exp2_q[$];
    exp_t        exp4_q[$];
    tx_t         rq[2][$];
    exp_t        e2, e4;
    tx_t         t2;
    int          w2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h", name, act);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus2.gnt != 2'b00) begin
                check("busy2_in_write", 32'(bus2.busy), 32'd1);
                if (!rnd) begin
                    if (exp2_q.size() == 0) begin
                        note_fail("gnt2_unexpected", 32'(bus2.gnt));
                    end else begin
                        e2 = exp2_q.pop_front();
                        check("gnt2", 32'(bus2.gnt), 32'(e2.gnt));
                        expq2 = e2.q;
                    end
                end else begin
                    w2 = (bus2.gnt == 2'b01) ? 0 : (bus2.gnt == 2'b10) ? 1 : -1;
                    if (w2 < 0 || rq[w2 < 0 ? 0 : w2].size() == 0) begin
                        note_fail("rnd_gnt_spurious", 32'(bus2.gnt));
                    end else begin
                        t2 = rq[w2].pop_front();
                        for (int k = 0; k < 2; k++)
                            if (t2.be[k]) model[8*k +: 8] = t2.wd[8*k +: 8];
                        expq2 = model;
                        if (cyc - t2.t0 > 4) note_fail("rnd_wait_cycles", 32'(cyc - t2.t0));
                        else tests++;
                    end
                end
                pend2 = 1'b1;
            end else if (pend2) begin
                check("q2", 32'(bus2.q), 32'(expq2));
                pend2 = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && bus4.gnt != 4'b0000) begin
            if (exp4_q.size() == 0) begin
                note_fail("gnt4_unexpected", 32'(bus4.gnt));
            end else begin
                e4 = exp4_q.pop_front();
                check("gnt4", 32'(bus4.gnt), 32'(e4.gnt));
            end
        end
    end

    task automatic wait_gnt2(input int i, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus2.gnt[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) note_fail("timeout_gnt2", 32'(bus2.gnt));
    endtask

    task automatic wr2(input int i, input logic [1:0] b, input logic [15:0] d, input logic [15:0] q_exp);
        bit   ok;
        exp_t e;
        @(negedge clk);
        bus2.be[i*2 +: 2]     = b;
        bus2.wdata[i*16 +: 16] = d;
        bus2.req[i]           = 1'b1;
        e.gnt = 8'(1) << i;
        e.q   = q_exp;
        exp2_q.push_back(e);
        wait_gnt2(i, ok);
        bus2.req[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic push4(input logic [7:0] g);
        exp_t e;
        e.gnt = g;
        e.q   = 16'h0000;
        exp4_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        bit          ok;
        logic [1:0]  rb;
        logic [15:0] rd;
        exp_t        e;

        resetn     = 1'b0;
        bus2.req   = 2'b11;
        bus2.be    = '0;
        bus2.wdata = 32'h1111_2222;
        bus4.req   = '0;
        bus4.be    = '0;
        bus4.wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_q", 32'(bus2.q), 32'h0);
        check("rst_gnt", 32'(bus2.gnt), 32'h0);
        check("rst_busy", 32'(bus2.busy), 32'h0);

        // Contention: both requesters held with be=0, alternating grants.
        for (int i = 0; i < 4; i++) begin
            e.gnt = (i % 2 == 0) ? 8'h01 : 8'h02;
            e.q   = 16'h0000;
            exp2_q.push_back(e);
        end
        mon_en = 1'b1;
        resetn = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c < 8) check("contend_busy", 32'(bus2.busy), (c % 2 == 0) ? 32'd1 : 32'd0);
            if (bus2.gnt != 2'b00) cnt++;
            if (cnt == 4) begin
                bus2.req = 2'b00;
                break;
            end
        end
        if (cnt < 4) note_fail("timeout_contend", 32'(cnt));
        repeat (2) @(negedge clk);

        // Reset asserted while a write is pending.
        mon_en = 1'b0;
        @(negedge clk);
        bus2.be    = 4'b0011;
        bus2.wdata = 32'h0000_5a5a;
        bus2.req   = 2'b01;
        wait_gnt2(0, ok);
        #1 resetn = 1'b0;
        #1;
        check("rst_mid_gnt", 32'(bus2.gnt), 32'h0);
        check("rst_mid_busy", 32'(bus2.busy), 32'h0);
        bus2.req = 2'b00;
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_q", 32'(bus2.q), 32'h0);
        pend2  = 1'b0;
        mon_en = 1'b1;

        // Directed writes and byte merging.
        wr2(0, 2'b11, 16'habcd, 16'habcd);
        wr2(0, 2'b10, 16'h1234, 16'h12cd);
        wr2(0, 2'b11, 16'habcd, 16'habcd);
        wr2(1, 2'b01, 16'hff55, 16'hab55);
        wr2(1, 2'b00, 16'h0000, 16'hab55);
        repeat (2) @(negedge clk);
        check("sb2_drain", 32'(exp2_q.size()), 32'd0);

        // Random traffic obeying the handshake.
        model = 16'hab55;
        rnd   = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (bus2.req[i] && bus2.gnt[i]) begin
                    bus2.req[i] = 1'b0;
                end else if (!bus2.req[i] && $urandom_range(0, 2) != 0) begin
                    rb = 2'($urandom);
                    rd = 16'($urandom);
                    bus2.be[i*2 +: 2]      = rb;
                    bus2.wdata[i*16 +: 16] = rd;
                    bus2.req[i]            = 1'b1;
                    rq[i].push_back('{rb, rd, cyc});
                end
            end
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (bus2.req[i] && bus2.gnt[i]) bus2.req[i] = 1'b0;
        end
        check("rnd_drain0", 32'(rq[0].size()), 32'd0);
        check("rnd_drain1", 32'(rq[1].size()), 32'd0);
        rnd = 1'b0;

        // Four requesters: wrap, then fairness with requester 2 dropped.
        @(negedge clk);
        push4(8'h01); push4(8'h02); push4(8'h04); push4(8'h08); push4(8'h01);
        bus4.req = 4'b1111;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus4.gnt != 4'b0000) begin
                cnt++;
                if (cnt == 5) begin
                    bus4.req = 4'b1011;
                    push4(8'h02); push4(8'h08); push4(8'h01);
                end
                if (cnt == 8) begin
                    bus4.req = 4'b0000;
                    break;
                end
            end
        end
        if (cnt < 8) note_fail("timeout_rr4", 32'(cnt));
        repeat (3) @(negedge clk);
        check("sb4_drain", 32'(exp4_q.size()), 32'd0);
        check("q4", 32'(bus4.q), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
